// File: rtl/instruction_fetch_queue_pkg.sv
// instruction_fetch_queue_pkg: shared constants and entry layout for the fetch queue
// Entry layout, LSB first: fault flag, then the 32-bit instruction, then the XLEN-bit pc.
package instruction_fetch_queue_pkg;
   localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
   localparam int FAULT_BIT = 0;
   localparam int INSTR_LSB = 1;
   localparam int PC_LSB = 33;
   function automatic int entry_w(input int xlen);
      return xlen + 33;
   endfunction
endpackage

// File: rtl/instruction_fetch_queue_fetch_queue.sv
// fetch_queue: synchronous FIFO with push/pop/flush, occupancy count and head data
// Ports: clk, reset (sync, active-high), push/pop/flush, wdata in, rdata (head) out, count out.
// A flush that coincides with a push leaves exactly the pushed entry in slot 0.
module fetch_queue #(
   parameter int W = 65,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   assign rdata = mem[rd_ptr];
   always_ff @(posedge clk)
      if (push) mem[flush ? '0 : wr_ptr] <= wdata;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= AW'(push);
         count <= (AW+1)'(push);
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: owns the fetch pc, captures imem words into a prefetch FIFO for decode
// Ports: clk, reset (sync, active-high); imem_pc/imem_instruction to instruction memory;
// redirect_valid/redirect_pc flush and retarget fetch; if_valid/if_ready/if_instruction/if_pc/if_fault
// present the queue head to decode; fill_level is the current occupancy.
// A misaligned redirect queues a single fault marker and halts fetch until an aligned redirect.
module instruction_fetch_queue
   import instruction_fetch_queue_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int FIFO_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   output logic [XLEN-1:0]               imem_pc,
   input  logic [31:0]                   imem_instruction,
   input  logic                          redirect_valid,
   input  logic [XLEN-1:0]               redirect_pc,
   output logic                          if_valid,
   input  logic                          if_ready,
   output logic [31:0]                   if_instruction,
   output logic [XLEN-1:0]               if_pc,
   output logic                          if_fault,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = entry_w(XLEN);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   logic [XLEN-1:0] fetch_pc;
   logic halted, pop, push, q_push;
   logic [EW-1:0] wdata, rdata;
   assign imem_pc = fetch_pc;
   assign if_valid = fill_level != '0;
   assign pop = if_valid & if_ready;
   assign push = !redirect_valid & !halted & (fill_level < FULL | pop);
   // during a redirect the only possible write is the misalignment marker
   assign q_push = redirect_valid ? |redirect_pc[1:0] : push;
   assign wdata = redirect_valid ? {redirect_pc, NOP_INSTRUCTION, 1'b1} : {fetch_pc, imem_instruction, 1'b0};
   assign if_instruction = if_valid ? rdata[INSTR_LSB +: 32] : NOP_INSTRUCTION;
   assign if_pc = if_valid ? rdata[PC_LSB +: XLEN] : '0;
   assign if_fault = if_valid & rdata[FAULT_BIT];
   fetch_queue #(.W(EW), .DEPTH(FIFO_DEPTH)) u_queue (
      .clk(clk),
      .reset(reset),
      .push(q_push),
      .pop(pop),
      .flush(redirect_valid),
      .wdata(wdata),
      .rdata(rdata),
      .count(fill_level)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_VECTOR;
         halted <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc;
         halted <= |redirect_pc[1:0];
      end else if (push) begin
         fetch_pc <= fetch_pc + XLEN'(4);
      end
   end
endmodule
